lut_class_argmax_reader: RTL and testbench

Reads the packed output vector of the final LUT neuron layer and reduces it to one predicted class index. The block sits between the last `layerN` neuron bank and the classification result port. It accepts one output vector per valid/ready handshake and scans the per-class codes sequentially, one class per cycle. It then presents the winning class, its code and a tie flag on a valid/ready output.

---
 rtl/lut_class_argmax_reader.sv | 117 +++++++++++
 tb/tb_lut_class_argmax_reader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_class_argmax_reader.sv
// Reduces the packed final-layer LUT neuron codes to a predicted class index,
// scanning one class per cycle and reporting the max code and a tie flag.
module lut_class_argmax_reader #(
  parameter int unsigned N_CLASSES = 5,
  parameter int unsigned BW        = 2,
  parameter int unsigned IDX_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [N_CLASSES*BW-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [IDX_W-1:0]        m_class,
  output logic [BW-1:0]           m_score,
  output logic                    m_tie
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_CLASSES - 1);
  localparam logic [IDX_W-1:0] FIRST_SCAN = IDX_W'(1);

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    vec_q [N_CLASSES];
  logic [BW-1:0]    vec_d [N_CLASSES];
  logic [BW-1:0]    best_q, best_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic             tie_q, tie_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
  logic [BW-1:0]    cur_code;

  assign cur_code = vec_q[cnt_q];

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    tie_d      = tie_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (s_valid && rdy_q) begin
          for (int unsigned i = 0; i < N_CLASSES; i++) begin
            vec_d[i] = s_data[i*BW +: BW];
          end
          best_d     = s_data[BW-1:0];
          best_idx_d = '0;
          tie_d      = 1'b0;
          cnt_d      = FIRST_SCAN;
          state_d    = (N_CLASSES == 1) ? ST_OUT : ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Strict greater-than keeps the lowest index on equal codes.
        if (cur_code > best_q) begin
          best_d     = cur_code;
          best_idx_d = cnt_q;
          tie_d      = 1'b0;
        end else if (cur_code == best_q) begin
          tie_d = 1'b1;
        end
        if (cnt_q == LAST_IDX) begin
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + FIRST_SCAN;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered ready: low throughout reset, high from the first edge after it.
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      best_q     <= '0;
      best_idx_q <= '0;
      tie_q      <= 1'b0;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      for (int unsigned i = 0; i < N_CLASSES; i++) begin
        vec_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      tie_q      <= tie_d;
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      for (int unsigned i = 0; i < N_CLASSES; i++) begin
        vec_q[i] <= vec_d[i];
      end
    end
  end

  assign s_ready = rdy_q;
  assign m_valid = (state_q == ST_OUT);
  assign m_class = best_idx_q;
  assign m_score = best_q;
  assign m_tie   = tie_q;

endmodule

// File: tb/tb_lut_class_argmax_reader.sv
// Directed bench for lut_class_argmax_reader: scoreboard of expected results
// for a 5-class instance plus a direct check of a 1-class instance.
module tb_lut_class_argmax_reader;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [9:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] m_class;
  logic [1:0] m_score;
  logic       m_tie;

  logic       s_valid1;
  logic       s_ready1;
  logic [1:0] s_data1;
  logic       m_valid1;
  logic       m_ready1;
  logic [0:0] m_class1;
  logic [1:0] m_score1;
  logic       m_tie1;

  typedef struct packed {
    logic [2:0] cls;
    logic [1:0] score;
    logic       tie;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   results  = 0;
  int   cyc      = 0;

  lut_class_argmax_reader #(.N_CLASSES(5), .BW(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_class(m_class), .m_score(m_score), .m_tie(m_tie)
  );

  lut_class_argmax_reader #(.N_CLASSES(1), .BW(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .m_valid(m_valid1), .m_ready(m_ready1),
    .m_class(m_class1), .m_score(m_score1), .m_tie(m_tie1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Max found first, then lowest index holding it; tie when it occurs more than once.
  function automatic exp_t model5(input logic [9:0] v);
    logic [1:0] c [5];
    logic [1:0] mx;
    int         hits;
    exp_t       r;
    for (int i = 0; i < 5; i++) c[i] = v[i*2 +: 2];
    mx = 2'd0;
    for (int i = 0; i < 5; i++) if (c[i] > mx) mx = c[i];
    hits  = 0;
    r.cls = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (c[i] == mx) begin
        hits++;
        r.cls = 3'(i);
      end
    end
    r.score = mx;
    r.tie   = (hits > 1);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      exp_t e;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("m_class", 32'(m_class), 32'(e.cls));
        chk("m_score", 32'(m_score), 32'(e.score));
        chk("m_tie",   32'(m_tie),   32'(e.tie));
        results++;
      end
    end
  end

  // Drives one vector and returns at #1 after the accepting edge.
  task automatic send(input logic [9:0] v, input bit keep_valid, output int acc_cyc);
    int n;
    s_data  = v;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    sb.push_back(model5(v));
    if (!keep_valid) s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, t0, t1, t2, n;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;
    s_valid1 = 1'b0;
    s_data1  = '0;
    m_ready1 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_class", 32'(m_class), 32'd0);
    chk("rst_m_score", 32'(m_score), 32'd0);
    chk("rst_m_tie",   32'(m_tie),   32'd0);
    chk("rst_s_ready1", 32'(s_ready1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);

    // basic max: class 3, score 3, no tie; latency N-1
    send(10'b0111001001, 1'b0, t0);
    chk("scan_s_ready", 32'(s_ready), 32'd0);
    wait_valid(lat);
    chk("basic_latency", 32'(lat), 32'd4);
    @(posedge clk); #1;
    chk("after_out_m_valid", 32'(m_valid), 32'd0);
    chk("after_out_s_ready", 32'(s_ready), 32'd1);

    // all-equal tie, then max at last index after an earlier equality
    send(10'b1010101010, 1'b0, t0);
    wait_valid(lat);
    chk("tie_latency", 32'(lat), 32'd4);
    send(10'b1101010000, 1'b0, t0);
    wait_valid(lat);
    chk("last_latency", 32'(lat), 32'd4);
    @(posedge clk); #1;

    // backpressure with ignored input pulses
    m_ready = 1'b0;
    send({2'b00, 2'b10, 2'b11, 2'b01, 2'b00}, 1'b0, t0);
    wait_valid(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 10; k++) begin
      s_valid = k[0];
      s_data  = 10'b1111111111;
      @(posedge clk); #1;
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_m_class", 32'(m_class), 32'd2);
      chk("bp_m_score", 32'(m_score), 32'd3);
      chk("bp_m_tie",   32'(m_tie),   32'd0);
      chk("bp_s_ready", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_m_valid", 32'(m_valid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("bp_no_ghost", 32'(m_valid), 32'd0);
    end

    // reset two cycles into scan
    send(10'b1111111111, 1'b0, t0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_m_class", 32'(m_class), 32'd0);
    chk("midrst_m_score", 32'(m_score), 32'd0);
    chk("midrst_m_tie",   32'(m_tie),   32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_s_ready", 32'(s_ready), 32'd1);
    send(10'b0000010000, 1'b0, t0);
    wait_valid(lat);
    chk("midrst_latency", 32'(lat), 32'd4);
    @(posedge clk); #1;

    // back-to-back with m_ready high: one acceptance every 6 cycles
    send({2'b01, 2'b10, 2'b11, 2'b11, 2'b00}, 1'b1, t0);
    send(10'b0000000000, 1'b1, t1);
    send({2'b11, 2'b10, 2'b01, 2'b00, 2'b10}, 1'b0, t2);
    chk("b2b_gap01", 32'(t1 - t0), 32'd6);
    chk("b2b_gap12", 32'(t2 - t1), 32'd6);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("result_count", 32'(results), 32'd8);

    // single-class instance: result one edge after acceptance
    @(posedge clk); #1;
    chk("n1_s_ready", 32'(s_ready1), 32'd1);
    s_data1  = 2'b10;
    s_valid1 = 1'b1;
    @(posedge clk); #1;
    s_valid1 = 1'b0;
    s_data1  = 2'b01;
    chk("n1_m_valid", 32'(m_valid1), 32'd1);
    chk("n1_m_class", 32'(m_class1), 32'd0);
    chk("n1_m_score", 32'(m_score1), 32'd2);
    chk("n1_m_tie",   32'(m_tie1),   32'd0);
    @(posedge clk); #1;
    chk("n1_done_m_valid", 32'(m_valid1), 32'd0);
    chk("n1_done_s_ready", 32'(s_ready1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
